// File: rtl/updown_counter_disp_pkg.sv
// Shared constants and seven-segment decode for the up/down display counter.
// Segment patterns are active-low, segment g in bit 6, segment a in bit 0.
package updown_counter_disp_pkg;

   localparam int RADIX_HEX = 16;
   localparam int RADIX_DEC = 10;
   localparam int DIG_W     = 4;
   localparam int SEG_W     = 7;

   typedef logic [DIG_W-1:0] digit_t;
   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic seg_t seg_decode(input digit_t d);
      return SEG_TABLE[d];
   endfunction

endpackage

// File: rtl/updown_counter_disp_digit.sv
// One counter digit of programmable radix with ripple carry/borrow.
// Loaded values above radix-1 are clamped so a decimal digit never exceeds 9.
module counter_digit
   import updown_counter_disp_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [4:0]   i_radix,
   input  logic         i_up,
   input  logic         i_cin,
   input  logic         i_load,
   input  digit_t       i_ld_val,
   input  logic         i_clr,
   output digit_t       o_q,
   output logic         o_cout
);

   digit_t r_q;
   digit_t w_max;
   digit_t w_ld;
   logic   w_at_lim;

   assign w_max    = DIG_W'(i_radix - 5'd1);
   assign w_at_lim = i_up ? (r_q == w_max) : (r_q == '0);
   assign w_ld     = (i_ld_val > w_max) ? w_max : i_ld_val;
   assign o_cout   = i_cin & w_at_lim;
   assign o_q      = r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= w_ld;
      end else if (i_cin) begin
         if (w_at_lim)
            r_q <= i_up ? '0 : w_max;
         else
            r_q <= i_up ? r_q + 4'd1 : r_q - 4'd1;
      end
   end

endmodule

// File: rtl/updown_counter_disp.sv
// Multi-digit hex/BCD up/down counter with terminal-count pulse
// and active-low seven-segment outputs per digit.
module updown_counter_disp
   import updown_counter_disp_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BCD    = 0
) (
   input  logic                   Clock,
   input  logic                   Resetn,
   input  logic                   Clear,
   input  logic                   Load,
   input  logic                   Enable,
   input  logic                   Up,
   input  logic [DIG_W*DIGITS-1:0] LoadValue,
   output logic [DIG_W*DIGITS-1:0] Q,
   output logic                   TC,
   output logic [SEG_W*DIGITS-1:0] HEX
);

   localparam logic [4:0] RADIX = (BCD != 0) ? 5'(RADIX_DEC) : 5'(RADIX_HEX);

   logic [DIGITS:0] w_carry;
   logic            r_tc;

   assign w_carry[0] = Enable;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      counter_digit u_dig (
         .clk      (Clock),
         .rst_n    (Resetn),
         .i_radix  (RADIX),
         .i_up     (Up),
         .i_cin    (w_carry[g]),
         .i_load   (Load),
         .i_ld_val (LoadValue[DIG_W*g +: DIG_W]),
         .i_clr    (Clear),
         .o_q      (Q[DIG_W*g +: DIG_W]),
         .o_cout   (w_carry[g+1])
      );
      assign HEX[SEG_W*g +: SEG_W] = seg_decode(Q[DIG_W*g +: DIG_W]);
   end

   // Top-digit carry only fires on an enabled wrap, so TC self-clears.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         r_tc <= 1'b0;
      else if (Clear || Load)
         r_tc <= 1'b0;
      else
         r_tc <= w_carry[DIGITS];
   end

   assign TC = r_tc;

endmodule

// File: tb/tb_updown_counter_disp.sv
// Directed bench for the up/down display counter in hex, BCD and
// single-digit configurations sharing one clock and control set.
module tb_updown_counter_disp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr, ld, en, up;
   logic [15:0] lv;

   logic [15:0] q_h, q_d;
   logic [3:0]  q_1;
   logic        tc_h, tc_d, tc_1;
   logic [27:0] hex_h, hex_d;
   logic [6:0]  hex_1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   updown_counter_disp #(.DIGITS(4), .BCD(0)) u_hex (
      .Clock(clk), .Resetn(rst_n), .Clear(clr), .Load(ld), .Enable(en),
      .Up(up), .LoadValue(lv), .Q(q_h), .TC(tc_h), .HEX(hex_h));

   updown_counter_disp #(.DIGITS(4), .BCD(1)) u_bcd (
      .Clock(clk), .Resetn(rst_n), .Clear(clr), .Load(ld), .Enable(en),
      .Up(up), .LoadValue(lv), .Q(q_d), .TC(tc_d), .HEX(hex_d));

   updown_counter_disp #(.DIGITS(1), .BCD(0)) u_one (
      .Clock(clk), .Resetn(rst_n), .Clear(clr), .Load(ld), .Enable(en),
      .Up(up), .LoadValue(lv[3:0]), .Q(q_1), .TC(tc_1), .HEX(hex_1));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr = 0; ld = 0; en = 0; up = 1; lv = '0;
      #12;
      chk("rst_q", 32'(q_h), 32'h0);
      chk("rst_tc", 32'(tc_h), 32'h0);
      chk("rst_hex", 32'(hex_h), 32'({4{7'b1000000}}));
      chk("rst_qd", 32'(q_d), 32'h0);
      rst_n = 1'b1;

      // full hex sweep with exactly one wrap pulse
      en = 1; up = 1;
      for (int i = 0; i < 65536; i++) begin
         step();
         chk("sweep_q", 32'(q_h), 32'((i + 1) & 16'hFFFF));
         chk("sweep_tc", 32'(tc_h), 32'(i == 65535));
         if (i == 14) begin
            chk("hex_F", 32'(hex_h[6:0]), 32'(7'b0001110));
            chk("hex_0", 32'(hex_h[13:7]), 32'(7'b1000000));
         end
      end

      // BCD carry and down wrap
      en = 0; ld = 1; lv = 16'h0999;
      step();
      chk("bcd_ld", 32'(q_d), 32'h0999);
      ld = 0; en = 1; up = 1;
      step();
      chk("bcd_up", 32'(q_d), 32'h1000);
      chk("bcd_up_tc", 32'(tc_d), 32'h0);
      en = 0; ld = 1; lv = 16'h0000;
      step();
      ld = 0; en = 1; up = 0;
      step();
      chk("bcd_dn", 32'(q_d), 32'h9999);
      chk("bcd_dn_tc", 32'(tc_d), 32'h1);
      en = 0;
      step();
      chk("hold_q", 32'(q_d), 32'h9999);
      chk("hold_tc", 32'(tc_d), 32'h0);

      // BCD clamp then up wrap
      ld = 1; lv = 16'hABCD;
      step();
      chk("clamp_q", 32'(q_d), 32'h9999);
      chk("clamp_tc", 32'(tc_d), 32'h0);
      chk("hexld_q", 32'(q_h), 32'hABCD);
      ld = 0; en = 1; up = 1;
      step();
      chk("bwrap_q", 32'(q_d), 32'h0000);
      chk("bwrap_tc", 32'(tc_d), 32'h1);
      chk("hinc_q", 32'(q_h), 32'hABCE);
      chk("hinc_hex", 32'(hex_h),
          32'({7'b0001000, 7'b0000011, 7'b1000110, 7'b0000110}));

      // priority: clear over load over enable
      clr = 1; ld = 1; en = 1; lv = 16'h1234;
      step();
      chk("prio_clr", 32'(q_h), 32'h0);
      chk("prio_clr_tc", 32'(tc_h), 32'h0);
      clr = 0;
      step();
      chk("prio_ld", 32'(q_h), 32'h1234);
      chk("prio_ld_d", 32'(q_d), 32'h1234);

      // down borrow across digits, then hex down wrap
      ld = 1; en = 0; lv = 16'h1000;
      step();
      ld = 0; en = 1; up = 0;
      step();
      chk("borrow", 32'(q_h), 32'h0FFF);
      en = 0; clr = 1;
      step();
      clr = 0; en = 1; up = 0;
      step();
      chk("hdn_q", 32'(q_h), 32'hFFFF);
      chk("hdn_tc", 32'(tc_h), 32'h1);

      // async reset mid-count
      en = 0; ld = 1; lv = 16'h00FE;
      step();
      ld = 0; en = 1; up = 1;
      step();
      chk("pre_rst", 32'(q_h), 32'h00FF);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_q", 32'(q_h), 32'h0);
      chk("arst_tc", 32'(tc_h), 32'h0);
      chk("arst_hex", 32'(hex_h), 32'({4{7'b1000000}}));
      #1 rst_n = 1'b1;
      step();
      chk("post_rst", 32'(q_h), 32'h0001);

      // single digit, direction toggled every edge
      en = 0; ld = 1; lv = 16'h000F;
      step();
      chk("one_ld", 32'(q_1), 32'hF);
      ld = 0; en = 1;
      for (int i = 0; i < 6; i++) begin
         up = (i % 2 == 0);
         step();
         chk("tog_q", 32'(q_1), (i % 2 == 0) ? 32'h0 : 32'hF);
         chk("tog_tc", 32'(tc_1), 32'h1);
      end
      en = 0;
      step();
      chk("tog_end_tc", 32'(tc_1), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
